// File: rtl/sequence_detector_pkg.sv
// Shared types and constants for the serial combination-lock detector.
package sequence_detector_pkg;

  localparam int unsigned CODE_LEN = 8;
  localparam int unsigned CNT_W    = 16;

  // State Sk = length of the longest history suffix equal to the code prefix inp[1:k].
  typedef logic [3:0] state_t;

  localparam state_t S0 = 4'd0;
  localparam state_t S1 = 4'd1;
  localparam state_t S2 = 4'd2;
  localparam state_t S3 = 4'd3;
  localparam state_t S4 = 4'd4;
  localparam state_t S5 = 4'd5;
  localparam state_t S6 = 4'd6;
  localparam state_t S7 = 4'd7;
  localparam state_t S8 = 4'd8;

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational longest-match search: largest k <= valid with the newest k
// history bits equal to inp[1:k] (hist[0] is the newest bit).
module seq_prefix_match
  import sequence_detector_pkg::*;
#(
  parameter int unsigned LEN = CODE_LEN
) (
  input  logic [LEN-1:0] hist,
  input  logic [3:0]     valid,
  input  logic [1:LEN]   inp,
  output state_t         match_k
);

  state_t cand [0:LEN];

  assign cand[0] = S0;

  // Each stage overrides the shorter candidate when its own prefix matches.
  for (genvar k = 1; k <= LEN; k++) begin : g_k
    logic [k-1:0] eq;
    logic         hit;

    for (genvar j = 1; j <= k; j++) begin : g_j
      assign eq[j-1] = (inp[j] == hist[k-j]);
    end

    assign hit     = (&eq) && (valid >= 4'(k));
    assign cand[k] = hit ? state_t'(k) : cand[k-1];
  end

  assign match_k = cand[LEN];

endmodule

// File: rtl/sequence_detector.sv
// Moore detector for an 8-bit serial unlock code with full overlap.
// Optional MATCH_COUNT_EN adds a saturating detection counter output.
module sequence_detector
  import sequence_detector_pkg::*;
#(
  parameter int unsigned LEN = CODE_LEN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_in,
  input  logic [1:LEN]     inp,
  output logic             y_out
`ifdef MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  localparam state_t S_FULL = state_t'(LEN);

  logic [LEN-1:0] hist;
  logic [LEN-1:0] hist_next;
  logic [3:0]     valid;
  logic [3:0]     valid_next;
  state_t         state;
  state_t         state_next;

  assign hist_next  = {hist[LEN-2:0], x_in};
  assign valid_next = (valid == 4'(LEN)) ? valid : valid + 4'd1;

  // Next state is recomputed from history against the live code every edge.
  seq_prefix_match #(.LEN(LEN)) u_match (
    .hist    (hist_next),
    .valid   (valid_next),
    .inp     (inp),
    .match_k (state_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist  <= '0;
      valid <= '0;
      state <= S0;
      y_out <= 1'b0;
    end else begin
      hist  <= hist_next;
      valid <= valid_next;
      state <= state_next;
      y_out <= (state_next == S_FULL);
    end
  end

  a_y_tracks_state : assert property (@(posedge clock) disable iff (!reset)
    y_out == (state == S_FULL));

`ifdef MATCH_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
    end else if ((state_next == S_FULL) && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Directed and reference-model checks for the serial code detector.
module tb_sequence_detector;

  logic        clock;
  logic        reset;
  logic        x_in;
  logic [1:8]  inp;
  logic        y_out;
`ifdef MATCH_COUNT_EN
  logic [15:0] match_count;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state for the random phase
  logic [7:0]  m_hist;
  int          m_cnt;
  int          m_matches;
  logic [7:0]  code;

  sequence_detector dut (
    .clock       (clock),
    .reset       (reset),
    .x_in        (x_in),
    .inp         (inp),
    .y_out       (y_out)
`ifdef MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one bit, clock it, sample 1 ns after the edge.
  task automatic step(input logic b);
    x_in = b;
    @(posedge clock);
    #1;
  endtask

  // Apply one bit and check y_out after the edge.
  task automatic step_chk(input logic b, input logic exp, input string tag);
    step(b);
    check(tag, {31'd0, y_out}, {31'd0, exp});
  endtask

  // Assert reset away from an edge; y_out must clear without a clock.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("rst_async_y", {31'd0, y_out}, 32'd0);
    @(posedge clock);
    #1;
    check("rst_hold_y", {31'd0, y_out}, 32'd0);
    reset = 1'b1;
  endtask

  // Send 8 bits MSB first (MSB is the earliest bit in time), checking each edge.
  task automatic send8(input logic [7:0] bits, input logic [7:0] exp, input string tag);
    logic [7:0] b;
    logic [7:0] e;
    b = bits;
    e = exp;
    for (int i = 0; i < 8; i++) begin
      step_chk(b[7], e[7], tag);
      b = b << 1;
      e = e << 1;
    end
  endtask

  initial begin
    reset = 1'b0;
    x_in  = 1'b0;
    inp   = 8'b10110010;
    #12;
    check("por_y", {31'd0, y_out}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // 1: single detection, then no match on a 9th '1'
    send8(8'b10110010, 8'b00000001, "t1_code");
    step_chk(1'b1, 1'b0, "t1_ninth");

    // 2: alternating code with overlap, detection at edges 8 and 10
    inp = 8'b10101010;
    do_reset();
    send8(8'b10101010, 8'b00000001, "t2_first");
    step_chk(1'b1, 1'b0, "t2_edge9");
    step_chk(1'b0, 1'b1, "t2_edge10");
`ifdef MATCH_COUNT_EN
    check("t6_count2", {16'd0, match_count}, 32'd2);
`endif

    // 3: all-zero code, stays high back-to-back
    inp = 8'b00000000;
    do_reset();
`ifdef MATCH_COUNT_EN
    check("t6_count_rst", {16'd0, match_count}, 32'd0);
`endif
    send8(8'b00000000, 8'b00000001, "t3_zeros");
    step_chk(1'b0, 1'b1, "t3_edge9");
    step_chk(1'b0, 1'b1, "t3_edge10");

    // y_out high, then asynchronous reset must clear it immediately
    inp = 8'b10110010;
    do_reset();

    // 4: partial code, mid-sequence reset, then full code needs 8 fresh bits
    step_chk(1'b1, 1'b0, "t4_part");
    step_chk(1'b0, 1'b0, "t4_part");
    step_chk(1'b1, 1'b0, "t4_part");
    step_chk(1'b1, 1'b0, "t4_part");
    step_chk(1'b0, 1'b0, "t4_part");
    do_reset();
    send8(8'b10110010, 8'b00000001, "t4_full");

    // live code change: history 10110010 now matches only a new code 10110010,
    // switching to a code ending 0100 gives a hit from the existing history
    inp = 8'b01100100;
    step_chk(1'b0, 1'b1, "t4_live_inp");

    // 5: random stream against a last-8-bits reference model
    m_matches = 0;
    for (int blk = 0; blk < 10; blk++) begin
      code = 8'($urandom);
      inp  = code;
      do_reset();
      m_hist = 8'd0;
      m_cnt  = 0;
      for (int n = 0; n < 200; n++) begin
        logic b;
        logic [7:0] rot;
        logic exp_y;
        if (n == 120) begin
          code = 8'($urandom);
          inp  = code;
        end
        rot = code << (n % 8);
        b = ($urandom_range(0, 3) == 0) ? 1'($urandom) : rot[7];
        step(b);
        m_hist = {m_hist[6:0], b};
        if (m_cnt < 8) m_cnt++;
        exp_y = (m_cnt >= 8) && (m_hist == code);
        if (exp_y) m_matches++;
        check("t5_rand", {31'd0, y_out}, {31'd0, exp_y});
      end
`ifdef MATCH_COUNT_EN
      check("t5_count", {16'd0, match_count}, 32'(m_matches));
      m_matches = 0;
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
